// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Oversample tick divider: integer truncation, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_hz / (baud * os);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; restart realigns the count to 0.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver: 8 data bits LSB first, parity, one stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around mid-bit.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       odd,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       busy,
  output logic       error,
  output logic       framing_error
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned MID = OVERSAMPLE / 2 - 1;

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_PRE    = SW'(MID - 1);
  localparam logic [SW-1:0] S_MID    = SW'(MID);
  localparam logic [SW-1:0] S_SAMPLE = SW'(MID + 1);
`else
  localparam logic [SW-1:0] S_SAMPLE = SW'(MID);
`endif
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t       state, state_d;
  logic            sync1, rx_s;
  logic [SW-1:0]   s_cnt, s_cnt_d;
  logic [BW-1:0]   bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            odd_q, odd_q_d;
  logic            perr, perr_d;
  logic            armed, armed_d;
  logic [7:0]      dout_d;
  logic            data_strobe_d, busy_d, error_d, framing_error_d;
  logic            restart_c, tick, sample_pt, wrap, bit_val;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  assign sample_pt = tick && (s_cnt == S_SAMPLE);
  assign wrap      = tick && (s_cnt == S_LAST);

`ifdef UART_RX_MAJORITY_EN
  // Samples taken one and two ticks before the decision point.
  logic maj_a, maj_b, maj_a_d, maj_b_d;

  always_comb begin
    maj_a_d = maj_a;
    maj_b_d = maj_b;
    if (tick && s_cnt == S_PRE) maj_a_d = rx_s;
    if (tick && s_cnt == S_MID) maj_b_d = rx_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      maj_a <= 1'b0;
      maj_b <= 1'b0;
    end else begin
      maj_a <= maj_a_d;
      maj_b <= maj_b_d;
    end
  end

  assign bit_val = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d         = state;
    s_cnt_d         = s_cnt;
    bit_idx_d       = bit_idx;
    shift_d         = shift;
    odd_q_d         = odd_q;
    perr_d          = perr;
    armed_d         = armed;
    dout_d          = dout;
    data_strobe_d   = 1'b0;
    busy_d          = busy;
    error_d         = error;
    framing_error_d = framing_error;
    restart_c       = 1'b0;

    if (tick) s_cnt_d = (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);

    case (state)
      IDLE: begin
        s_cnt_d = '0;
        if (rx_s) armed_d = 1'b1;
        if (!rx_s && armed) begin
          state_d   = START;
          restart_c = 1'b1;
          odd_q_d   = odd;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (sample_pt && bit_val) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (sample_pt) shift_d = {bit_val, shift[7:1]};
        if (wrap) begin
          if (bit_idx == B_LAST) state_d = PARITY;
          else bit_idx_d = bit_idx + BW'(1);
        end
      end
      PARITY: begin
        if (sample_pt) perr_d = (bit_val != ((^shift) ^ odd_q));
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Exit at mid-stop so a back-to-back start edge is not missed.
        if (sample_pt) begin
          dout_d          = shift;
          error_d         = perr;
          framing_error_d = ~bit_val;
          data_strobe_d   = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
          if (!bit_val) armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      s_cnt         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      odd_q         <= 1'b0;
      perr          <= 1'b0;
      armed         <= 1'b0;
      dout          <= '0;
      data_strobe   <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync1         <= rx_in;
      rx_s          <= sync1;
      state         <= state_d;
      s_cnt         <= s_cnt_d;
      bit_idx       <= bit_idx_d;
      shift         <= shift_d;
      odd_q         <= odd_q_d;
      perr          <= perr_d;
      armed         <= armed_d;
      dout          <= dout_d;
      data_strobe   <= data_strobe_d;
      busy          <= busy_d;
      error         <= error_d;
      framing_error <= framing_error_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: directed scenarios plus random frames.
module tb_uart_rx_oversample;

  localparam int unsigned BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic       odd = 1'b0;
  logic [7:0] dout;
  logic       data_strobe, busy, error, framing_error;

  uart_rx_oversample #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .odd           (odd),
    .dout          (dout),
    .data_strobe   (data_strobe),
    .busy          (busy),
    .error         (error),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic       fe;
  } exp_t;

  exp_t        sb[$];
  int unsigned strobe_cyc[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: parity bit a correct transmitter would send.
  function automatic logic tx_parity(input logic [7:0] d, input logic o);
    return (^d) ^ o;
  endfunction

  task automatic expect_frame(input logic [7:0] recv, input logic o, input logic pbit,
                              input logic stop);
    exp_t e;
    e.data = recv;
    e.err  = (pbit != tx_parity(recv, o));
    e.fe   = ~stop;
    sb.push_back(e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (data_strobe === 1'b1) begin
        strobe_cyc.push_back(cyc);
        check("busy_at_strobe", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe with dout 0x%0h, expected none", dout);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dout", 32'(dout), 32'(e.data));
          check("error", 32'(error), 32'(e.err));
          check("framing_error", 32'(framing_error), 32'(e.fe));
        end
      end
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) edge_wait();
  endtask

  // Drives start, 8 data bits, parity, stop; optionally inverts the mid sample of one bit.
  task automatic send_frame(input logic [7:0] d, input logic o, input logic pbit,
                            input logic stop, input int glitch_bit, input bit chk_busy);
    logic [10:0] bits;
    bits = {stop, pbit, d, 1'b0};
    odd  = o;
    for (int n = 0; n < 11; n++) begin
      for (int k = 0; k < BIT_CLKS; k++) begin
        rx_in = (n == glitch_bit && k == 8) ? ~bits[n] : bits[n];
        edge_wait();
        if (chk_busy && n == 0 && k == 1) check("busy_before_rise", 32'(busy), 32'd0);
        if (chk_busy && n == 0 && k == 2) check("busy_rise", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      edge_wait();
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int unsigned n0;
    logic [10:0] bits;
    logic [7:0]  d, recv;
    logic        o, pbit;

    fork
      monitor();
      begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) edge_wait();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_strobe", 32'(data_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_framing", 32'(framing_error), 32'd0);
    reset = 1'b1;
    idle(20);

    // Clean frame, even parity
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    idle(20);
    wait_drain(200);

    // Parity error, odd parity
    expect_frame(8'h01, 1'b1, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    idle(20);
    wait_drain(200);

    // Short low glitch on idle line
    n0 = strobe_cyc.size();
    rx_in = 1'b0;
    repeat (4) edge_wait();
    rx_in = 1'b1;
    repeat (12) edge_wait();
    check("glitch_busy_clear", 32'(busy), 32'd0);
    idle(40);
    check("glitch_no_strobe", strobe_cyc.size() - n0, 32'd0);

    // Break: stop low, line held low, then recovery frame
    n0 = strobe_cyc.size();
    expect_frame(8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    rx_in = 1'b0;
    repeat (40 * BIT_CLKS) edge_wait();
    idle(BIT_CLKS);
    expect_frame(8'h3C, 1'b0, tx_parity(8'h3C, 1'b0), 1'b1);
    send_frame(8'h3C, 1'b0, tx_parity(8'h3C, 1'b0), 1'b1, -1, 1'b0);
    idle(20);
    wait_drain(200);
    check("break_strobe_count", strobe_cyc.size() - n0, 32'd2);

    // Back-to-back frames
    n0 = strobe_cyc.size();
    expect_frame(8'h55, 1'b0, tx_parity(8'h55, 1'b0), 1'b1);
    expect_frame(8'hAA, 1'b1, tx_parity(8'hAA, 1'b1), 1'b1);
    send_frame(8'h55, 1'b0, tx_parity(8'h55, 1'b0), 1'b1, -1, 1'b0);
    send_frame(8'hAA, 1'b1, tx_parity(8'hAA, 1'b1), 1'b1, -1, 1'b0);
    idle(20);
    wait_drain(200);
    if (strobe_cyc.size() >= n0 + 2)
      check("b2b_spacing", strobe_cyc[n0 + 1] - strobe_cyc[n0], 32'd176);
    else
      check("b2b_strobe_count", strobe_cyc.size() - n0, 32'd2);

    // Reset pulse during data bit 4 of 0x5A
    n0 = strobe_cyc.size();
    odd = 1'b0;
    bits = {1'b1, tx_parity(8'h5A, 1'b0), 8'h5A, 1'b0};
    for (int c = 0; c < BIT_CLKS * 5 + 8; c++) begin
      rx_in = bits[c / BIT_CLKS];
      edge_wait();
    end
    check("midframe_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    edge_wait();
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_strobe", 32'(data_strobe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_framing", 32'(framing_error), 32'd0);
    reset = 1'b1;
    idle(40);
    check("abort_no_strobe", strobe_cyc.size() - n0, 32'd0);
    expect_frame(8'h7E, 1'b0, tx_parity(8'h7E, 1'b0), 1'b1);
    send_frame(8'h7E, 1'b0, tx_parity(8'h7E, 1'b0), 1'b1, -1, 1'b0);
    idle(20);
    wait_drain(200);

    // Single-sample corruption at mid of data bit 3 of 0xF0
    pbit = tx_parity(8'hF0, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    recv = 8'hF0;
`else
    recv = 8'hF8;
`endif
    expect_frame(recv, 1'b0, pbit, 1'b1);
    send_frame(8'hF0, 1'b0, pbit, 1'b1, 4, 1'b0);
    idle(20);
    wait_drain(200);

    // Random frames, occasional parity corruption, random gaps
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      o    = 1'($urandom);
      pbit = tx_parity(d, o) ^ ($urandom_range(0, 3) == 0);
      expect_frame(d, o, pbit, 1'b1);
      send_frame(d, o, pbit, 1'b1, -1, 1'b0);
      idle(int'($urandom_range(0, 30)));
    end
    idle(20);
    wait_drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
